// File: rtl/microcode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : microcode_sequencer                                             |
// | Brief    : Micro-PC engine: dispatch, sequence/branch/stall, ctrl issue.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module microcode_sequencer #(
  parameter int AW       = 8,
  parameter int IW       = 32,
  parameter int CW       = 8,
  parameter int WDOG_MAX = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [AW-1:0]    cmd_entry,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic [CW-1:0]    cond_in,
  input  logic             ack_in,
  output logic [AW-1:0]    uaddr,
  input  logic [IW-1:0]    uinstr,
  output logic [IW-15:0]   ctrl_out,
  output logic             ctrl_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int c_WDOG_W = $clog2(WDOG_MAX + 1);

  localparam logic [1:0] c_OP_NEXT = 2'b00;
  localparam logic [1:0] c_OP_JUMP = 2'b01;
  localparam logic [1:0] c_OP_BR   = 2'b10;
  localparam logic [1:0] c_OP_END  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_upc, w_upc_nxt;
  logic [IW-15:0]      r_ctrl, w_ctrl_nxt;
  logic                r_ctrl_valid, w_ctrl_valid_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [c_WDOG_W-1:0] r_wdog, w_wdog_nxt;

  logic [AW-1:0]       w_target;
  logic [1:0]          w_seq_op;
  logic [2:0]          w_cond_sel;
  logic                w_wait;
  logic [7:0]          w_cond_ext;
  logic                w_cond;
  logic                w_exec;
  logic                w_end_exec;
  logic [AW-1:0]       w_upc_inc;

  assign w_target   = AW'(uinstr[7:0]);
  assign w_seq_op   = uinstr[9:8];
  assign w_cond_sel = uinstr[12:10];
  assign w_wait     = uinstr[13];

  // Selectors beyond the implemented conditions read as zero (branch not taken).
  generate
    if (CW >= 8) begin : g_cond_trunc
      assign w_cond_ext = cond_in[7:0];
    end else begin : g_cond_pad
      assign w_cond_ext = {{(8-CW){1'b0}}, cond_in};
    end
  endgenerate

  assign w_cond     = w_cond_ext[w_cond_sel];
  assign w_exec     = ~w_wait | ack_in;
  assign w_end_exec = w_exec & (w_seq_op == c_OP_END);
  assign w_upc_inc  = r_upc + {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_upc        <= '0;
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_upc        <= w_upc_nxt;
      r_ctrl       <= w_ctrl_nxt;
      r_ctrl_valid <= w_ctrl_valid_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_wdog       <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_upc_nxt        = r_upc;
    w_ctrl_nxt       = r_ctrl;
    w_ctrl_valid_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    w_wdog_nxt       = r_wdog;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_upc_nxt   = cmd_entry;
          w_wdog_nxt  = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Abort outranks everything, including an END executing this cycle.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if ((r_wdog == c_WDOG_W'(WDOG_MAX)) && !w_end_exec) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + {{(c_WDOG_W-1){1'b0}}, 1'b1};
          if (w_exec) begin
            w_ctrl_nxt       = uinstr[IW-1:14];
            w_ctrl_valid_nxt = 1'b1;
            case (w_seq_op)
              c_OP_NEXT: w_upc_nxt = w_upc_inc;
              c_OP_JUMP: w_upc_nxt = w_target;
              c_OP_BR:   w_upc_nxt = w_cond ? w_target : w_upc_inc;
              default: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            endcase
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign uaddr      = r_upc;
  assign ctrl_out   = r_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_microcode_sequencer                                          |
// | Brief    : Directed self-checking bench with a behavioural ROM.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_microcode_sequencer;

  localparam int AW = 8;
  localparam int IW = 32;
  localparam int CW = 4;
  localparam int WDOG_MAX = 1023;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [AW-1:0] cmd_entry;
  logic          cmd_ready;
  logic          abort;
  logic [CW-1:0] cond_in;
  logic          ack_in;
  logic [AW-1:0] uaddr;
  logic [IW-1:0] uinstr;
  logic [17:0]   ctrl_out;
  logic          ctrl_valid;
  logic          busy;
  logic          done;
  logic          err;

  logic [31:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign uinstr = rom[uaddr];

  microcode_sequencer #(.AW(AW), .IW(IW), .CW(CW), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_entry(cmd_entry),
    .cmd_ready(cmd_ready), .abort(abort), .cond_in(cond_in), .ack_in(ack_in),
    .uaddr(uaddr), .uinstr(uinstr), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [31:0] mk(input logic [17:0] c, input logic w,
                                     input logic [2:0] cs, input logic [1:0] op,
                                     input logic [7:0] t);
    return {c, w, cs, op, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [7:0] e);
    cmd_valid = 1'b1;
    cmd_entry = e;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl_valid: got %b want 0", ctrl_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    n_cmp++; if (uaddr !== 8'h00 || ctrl_out !== 18'h0) begin n_bad++; $display("FAIL reset_regs: got uaddr %h ctrl %h want 00/0", uaddr, ctrl_out); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    logic [17:0] seen [3];
    int nv = 0, nd = 0, done_at = -1;
    dispatch(8'h00);
    n_cmp++; if (uaddr !== 8'h00 || busy !== 1'b1 || ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL seq_fetch: got uaddr %h busy %b cv %b want 00/1/0", uaddr, busy, ctrl_valid); end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (ctrl_valid) begin
        if (nv < 3) seen[nv] = ctrl_out;
        nv++;
      end
      if (done) begin nd++; done_at = c; end
    end
    n_cmp++; if (nv !== 3) begin n_bad++; $display("FAIL seq_count: got %0d want 3", nv); end
    n_cmp++; if (seen[0] !== 18'h100 || seen[1] !== 18'h101 || seen[2] !== 18'h102) begin n_bad++; $display("FAIL seq_order: got %h %h %h want 100 101 102", seen[0], seen[1], seen[2]); end
    n_cmp++; if (nd !== 1 || done_at !== 3) begin n_bad++; $display("FAIL seq_done: got %0d at %0d want 1 at 3", nd, done_at); end
  endtask

  task automatic test_jump();
    dispatch(8'h05);
    n_cmp++; if (uaddr !== 8'h05) begin n_bad++; $display("FAIL jump_first: got %h want 05", uaddr); end
    tick();
    n_cmp++; if (uaddr !== 8'h40 || ctrl_valid !== 1'b1 || ctrl_out !== 18'h205) begin n_bad++; $display("FAIL jump_target: got %h cv %b ctrl %h want 40/1/205", uaddr, ctrl_valid, ctrl_out); end
    tick();
    n_cmp++; if (done !== 1'b1 || cmd_ready !== 1'b1 || ctrl_out !== 18'h240) begin n_bad++; $display("FAIL jump_end: got done %b rdy %b ctrl %h want 1/1/240", done, cmd_ready, ctrl_out); end
    tick();
    n_cmp++; if (done !== 1'b0 || ctrl_valid !== 1'b0 || uaddr !== 8'h40) begin n_bad++; $display("FAIL jump_after: got done %b cv %b uaddr %h want 0/0/40", done, ctrl_valid, uaddr); end
  endtask

  task automatic test_branch();
    cond_in = 4'h8;
    dispatch(8'h10); tick();
    n_cmp++; if (uaddr !== 8'h20) begin n_bad++; $display("FAIL br_taken: got %h want 20", uaddr); end
    wait_idle(); tick();
    cond_in = 4'h0;
    dispatch(8'h10); tick();
    n_cmp++; if (uaddr !== 8'h11) begin n_bad++; $display("FAIL br_not_taken: got %h want 11", uaddr); end
    wait_idle(); tick();
    cond_in = 4'hF;
    dispatch(8'h30); tick();
    n_cmp++; if (uaddr !== 8'h31) begin n_bad++; $display("FAIL br_sel_oob: got %h want 31", uaddr); end
    wait_idle(); tick();
    cond_in = 4'h0;
  endtask

  task automatic test_wait();
    int bad_stall = 0;
    ack_in = 1'b0;
    dispatch(8'h50);
    for (int i = 0; i < 5; i++) begin
      if (uaddr !== 8'h50 || ctrl_valid !== 1'b0) bad_stall++;
      tick();
    end
    n_cmp++; if (bad_stall !== 0) begin n_bad++; $display("FAIL wait_stall: got %0d bad cycles want 0", bad_stall); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    n_cmp++; if (ctrl_valid !== 1'b1 || ctrl_out !== 18'h250 || uaddr !== 8'h51) begin n_bad++; $display("FAIL wait_release: got cv %b ctrl %h uaddr %h want 1/250/51", ctrl_valid, ctrl_out, uaddr); end
    tick();
    n_cmp++; if (done !== 1'b1 || ctrl_out !== 18'h251) begin n_bad++; $display("FAIL wait_end: got done %b ctrl %h want 1/251", done, ctrl_out); end
    tick();
  endtask

  task automatic test_wrap();
    dispatch(8'hFF);
    tick();
    n_cmp++; if (uaddr !== 8'h00 || ctrl_out !== 18'h1FF) begin n_bad++; $display("FAIL wrap: got uaddr %h ctrl %h want 00/1ff", uaddr, ctrl_out); end
    wait_idle(); tick();
  endtask

  task automatic test_watchdog();
    int n = 0, nd = 0;
    dispatch(8'h60);
    while (busy && n < 2000) begin
      if (done) nd++;
      n++;
      tick();
    end
    if (done) nd++;
    n_cmp++; if (n !== WDOG_MAX + 1) begin n_bad++; $display("FAIL wdog_cycles: got %0d want %0d", n, WDOG_MAX + 1); end
    n_cmp++; if (err !== 1'b1 || nd !== 0 || ctrl_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wdog_flags: got err %b done# %0d cv %b rdy %b want 1/0/0/1", err, nd, ctrl_valid, cmd_ready); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wdog_sticky: got %b want 1", err); end
    dispatch(8'h05);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wdog_clear: got %b want 0", err); end
    wait_idle(); tick();
  endtask

  task automatic test_abort();
    abort = 1'b1;
    dispatch(8'h70);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b1 || uaddr !== 8'h70) begin n_bad++; $display("FAIL abort_idle: got busy %b uaddr %h want 1/70", busy, uaddr); end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, ctrl_valid, done, cmd_ready} !== 4'b0001) begin n_bad++; $display("FAIL abort_end: got b/cv/d/rdy %b want 0001", {busy, ctrl_valid, done, cmd_ready}); end
    tick();
    n_cmp++; if (done !== 1'b0 || ctrl_valid !== 1'b0) begin n_bad++; $display("FAIL abort_after: got done %b cv %b want 0/0", done, ctrl_valid); end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_entry = 8'h05;
    tick();
    tick();
    n_cmp++; if (uaddr !== 8'h40 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored: got uaddr %h rdy %b want 40/0", uaddr, cmd_ready); end
    tick();
    n_cmp++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got done %b rdy %b want 1/1", done, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || uaddr !== 8'h05) begin n_bad++; $display("FAIL b2b_redispatch: got busy %b uaddr %h want 1/05", busy, uaddr); end
    wait_idle(); tick();
  endtask

  task automatic test_reset_mid();
    dispatch(8'h00);
    tick();
    n_cmp++; if (ctrl_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got cv %b want 1", ctrl_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, ctrl_valid, done, err, cmd_ready} !== 5'b00001) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 00001", {busy, ctrl_valid, done, err, cmd_ready}); end
    n_cmp++; if (uaddr !== 8'h00 || ctrl_out !== 18'h0) begin n_bad++; $display("FAIL rst_mid_regs: got uaddr %h ctrl %h want 00/0", uaddr, ctrl_out); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_after: got done %b rdy %b want 0/1", done, cmd_ready); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(18'h3FFFF, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h00] = mk(18'h100, 1'b0, 3'd0, 2'b00, 8'h00);
    rom[8'h01] = mk(18'h101, 1'b0, 3'd0, 2'b00, 8'h00);
    rom[8'h02] = mk(18'h102, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h05] = mk(18'h205, 1'b0, 3'd0, 2'b01, 8'h40);
    rom[8'h40] = mk(18'h240, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h10] = mk(18'h210, 1'b0, 3'd3, 2'b10, 8'h20);
    rom[8'h11] = mk(18'h211, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h20] = mk(18'h220, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h30] = mk(18'h230, 1'b0, 3'd7, 2'b10, 8'h20);
    rom[8'h31] = mk(18'h231, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h50] = mk(18'h250, 1'b1, 3'd0, 2'b00, 8'h00);
    rom[8'h51] = mk(18'h251, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'h60] = mk(18'h260, 1'b0, 3'd0, 2'b01, 8'h60);
    rom[8'h70] = mk(18'h270, 1'b0, 3'd0, 2'b00, 8'h00);
    rom[8'h71] = mk(18'h271, 1'b0, 3'd0, 2'b11, 8'h00);
    rom[8'hFF] = mk(18'h1FF, 1'b0, 3'd0, 2'b00, 8'h00);
    cmd_valid = 1'b0; cmd_entry = 8'h00; abort = 1'b0; cond_in = 4'h0; ack_in = 1'b0;
    test_reset();
    test_sequence();
    test_jump();
    test_branch();
    test_wait();
    test_wrap();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
